// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and access decode for the load/store unit
package lsu_pkg;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_t;

    // Faults that can be decided before touching memory; illegal width wins over alignment.
    function automatic logic [1:0] decode_fault(input logic write, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic illegal;
        if (write) illegal = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
        else       illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (illegal)                           return FAULT_ILLEGAL;
        if ((f3[1:0] == 2'b01) && off[0])      return FAULT_MISALIGN;
        if ((f3[1:0] == 2'b10) && (off != 2'b00)) return FAULT_MISALIGN;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select with sign/zero extension
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] lane;

    assign lane = word >> {byte_off, 3'b000};

    // Pick the addressed byte/half and extend it according to the load width.
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane[15:0]};
            F3_W:    data = word;
            F3_BU:   data = {24'h0, lane[7:0]};
            F3_HU:   data = {16'h0, lane[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with req/ack memory port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid,
    input  logic        ls_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [7:0]  cnt;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [1:0]  dec_fault;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [31:0] ext_data;

    // Width and offset are latched at issue so extension does not depend on the core holding them.
    load_extend u_load_extend (
        .funct3   (op_f3),
        .byte_off (op_off),
        .word     (mem_rdata),
        .data     (ext_data)
    );

    assign stall     = ls_valid & (state != ST_RESP);
    assign dec_fault = decode_fault(ls_write, funct3, addr[1:0]);

    // Byte enables and lane-replicated store data for the access being issued.
    always_comb begin
        be_next = 4'b1111;
        wd_next = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_next = 4'b0001 << addr[1:0];
                wd_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next = addr[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = wdata;
            end
        endcase
    end

    // Access FSM: decode in IDLE, hold the memory request in BUSY, pulse done in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_f3     <= '0;
            op_off    <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            fault     <= FAULT_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ls_valid) begin
                        if (dec_fault != FAULT_NONE) begin
                            state <= ST_RESP;
                            done  <= 1'b1;
                            fault <= dec_fault;
                            rdata <= '0;
                        end else begin
                            state     <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= ls_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wd_next;
                            cnt       <= '0;
                            op_f3     <= funct3;
                            op_off    <= addr[1:0];
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        state   <= ST_RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= FAULT_NONE;
                        rdata   <= mem_we ? 32'h0 : ext_data;
                    end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                        state   <= ST_RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= FAULT_TIMEOUT;
                        rdata   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the core datapath's ALU, replacing the ideal single-cycle data memory port. It takes the effective address and store data, drives a variable-latency memory with a req/ack handshake, and returns aligned, sign- or zero-extended load data. While an access is outstanding it stalls the core, which holds PC and operands. Misaligned, illegal-funct3 and timed-out accesses are reported as faults.

## Interface
- TIMEOUT_CYC, 255, max BUSY cycles without `mem_ack` before a bus-timeout fault (1..255)
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- ls_valid  in  1  load/store instruction in execute; held with operands while `stall`=1
- ls_write  in  1  1=store, 0=load
- funct3  in  3  RV32I width/sign: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (rs2)
- stall  out  1  freeze PC/register writeback
- done  out  1  one-cycle completion pulse; core commits `rdata` this cycle
- rdata  out  32  extended load data, valid while `done`=1
- fault  out  2  valid while `done`=1: 00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write strobe
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  request complete; `mem_rdata` valid the same cycle
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when `ls_valid`=1, decode funct3/addr:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010. Go to RESP with fault=11.
  - Misaligned: half with addr[0]=1, word with addr[1:0]≠00. Go to RESP with fault=01.
  - Otherwise: register mem_addr/mem_we/mem_be/mem_wdata, clear timeout counter, go to BUSY.
- BUSY: `mem_req`=1; all mem_* outputs stable.
  - `mem_ack`=1: capture extended load data (stores capture 0), fault=00, go to RESP.
  - No ack: counter increments. On reaching TIMEOUT_CYC, go to RESP with fault=10 and rdata=0.
- RESP: `done`=1, then go to IDLE unconditionally. The core advances PC at the end of this cycle, so a `ls_valid` seen in the next IDLE belongs to a new instruction.
- Byte enables and store data:
  - SB: `mem_be`=0001<<addr[1:0], data={4{wdata[7:0]}}.
  - SH: `mem_be`=addr[1]?1100:0011, data={2{wdata[15:0]}}.
  - SW: `mem_be`=1111.
- Loads: lane = `mem_rdata`>>(8·addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Faulted accesses never assert `mem_req`; faulted `rdata`=0.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset (`rst`=0 at an edge) forces IDLE; all outputs and the counter go to 0, including mid-BUSY. The memory side must tolerate an abandoned request.
- `stall` = `ls_valid` & (state≠RESP), combinational. All other outputs are registered.
- Minimum access is 3 cycles (IDLE, BUSY with same-cycle ack, RESP), giving 2 stall cycles.
- Each cycle of ack latency adds one stall cycle.
- Fault detected in IDLE: 2 cycles, 1 stall cycle.
- Timeout: RESP follows the BUSY cycle in which the counter reaches TIMEOUT_CYC with no ack.
- Ack arriving in that same final cycle wins: the access completes normally.

## Structure
- `lsu_pkg`: funct3 encodings, fault codes, FSM state encoding, and the default TIMEOUT_CYC.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension of `mem_rdata`, driven by funct3 and addr[1:0].

## Test plan
- LW addr 0x100, ack after 0 wait cycles with `mem_rdata` 0xDEADBEEF: stall high 2 cycles, `done` on cycle 3, `rdata`=0xDEADBEEF, fault=00.
- LB addr 0x103, `mem_rdata` 0x80112233: `rdata`=0xFFFFFF80. LBU same access: `rdata`=0x00000080. LHU addr 0x102: `rdata`=0x00008011.
- SH addr 0x206, `wdata` 0x0000ABCD, ack after 3 cycles: `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x204, 5 stall cycles.
- LW addr 0x101: no `mem_req` ever; `done` on cycle 2 with fault=01, `rdata`=0. Store funct3=011: fault=11.
- TIMEOUT_CYC=4, never ack: `mem_req` high exactly 4 cycles, then `done` with fault=10. A late ack arriving in IDLE is ignored.
- `rst`=0 during BUSY: next cycle `mem_req`=0, `stall`=0, state IDLE; after release a fresh LW completes normally.
